stream_xbar_rsp_router: RTL and testbench

- Return-path companion to the stream crossbar.
- Gates request handshakes between NumInp initiators and the crossbar request side, and tracks per-initiator outstanding transactions.
- Routes responses from NumOut targets back to the originating initiator, using the source index each target echoes with its response.
- Ordering guarantee: an initiator may have outstanding requests to only one target at a time, so responses arrive in order and cyclic response deadlock cannot occur.

---
 rtl/stream_xbar_rsp_router.sv | 148 ++++++++++++++
 tb/tb_stream_xbar_rsp_router.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_xbar_rsp_router.sv
// Request gate and response return router for the stream crossbar.
// Per-initiator outstanding count and target keep responses ordered and routable.
module stream_xbar_rsp_router #(
    parameter int unsigned NumInp   = 2,
    parameter int unsigned NumOut   = 2,
    parameter int unsigned RspWidth = 32,
    parameter int unsigned MaxTxns  = 4,
    localparam int unsigned SelWidth = (NumOut > 1) ? $clog2(NumOut) : 1,
    localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1,
    localparam int unsigned CntWidth = $clog2(MaxTxns + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumInp-1:0]            req_valid_i,
    output logic [NumInp-1:0]            req_ready_o,
    input  logic [NumInp*SelWidth-1:0]   req_sel_i,
    output logic [NumInp-1:0]            req_valid_o,
    input  logic [NumInp-1:0]            req_ready_i,
    input  logic [NumOut*RspWidth-1:0]   rsp_data_i,
    input  logic [NumOut*IdxWidth-1:0]   rsp_idx_i,
    input  logic [NumOut-1:0]            rsp_valid_i,
    output logic [NumOut-1:0]            rsp_ready_o,
    output logic [NumInp*RspWidth-1:0]   rsp_data_o,
    output logic [NumInp-1:0]            rsp_valid_o,
    input  logic [NumInp-1:0]            rsp_ready_i,
    output logic [NumInp-1:0]            busy_o,
    output logic                         rsp_err_o
);

    logic [SelWidth-1:0] sel   [NumInp];
    logic [SelWidth-1:0] tgt_q [NumInp];
    logic [SelWidth-1:0] tgt_d [NumInp];
    logic [CntWidth-1:0] cnt_q [NumInp];
    logic [CntWidth-1:0] cnt_d [NumInp];
    logic [IdxWidth-1:0] idx   [NumOut];
    logic [RspWidth-1:0] rdata [NumOut];
    logic [NumOut-1:0]   hit   [NumInp];
    logic [NumInp-1:0]   allow;
    logic [NumInp-1:0]   req_fire;
    logic [NumInp-1:0]   rsp_fire;
    logic [NumOut-1:0]   routable;
    logic                err_q;
    logic                err_d;

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            sel[i] = req_sel_i[i*SelWidth +: SelWidth];
        end
        for (int t = 0; t < NumOut; t++) begin
            idx[t]   = rsp_idx_i[t*IdxWidth +: IdxWidth];
            rdata[t] = rsp_data_i[t*RspWidth +: RspWidth];
        end
    end

    // The gate looks only at registered state, so a response retiring this
    // cycle never opens the gate until the next one.
    always_comb begin
        allow       = '0;
        req_valid_o = '0;
        req_ready_o = '0;
        req_fire    = '0;
        busy_o      = '0;
        for (int i = 0; i < NumInp; i++) begin
            allow[i]       = (cnt_q[i] != CntWidth'(MaxTxns)) &&
                             ((cnt_q[i] == '0) || (sel[i] == tgt_q[i]));
            req_valid_o[i] = req_valid_i[i] & allow[i];
            req_ready_o[i] = req_ready_i[i] & allow[i];
            req_fire[i]    = req_valid_o[i] & req_ready_i[i];
            busy_o[i]      = (cnt_q[i] != '0);
        end
    end

    // hit[i][t]: target t currently carries a response that belongs to initiator i.
    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            hit[i] = '0;
            for (int t = 0; t < NumOut; t++) begin
                hit[i][t] = (cnt_q[i] != '0) && (tgt_q[i] == SelWidth'(t)) &&
                            (idx[t] == IdxWidth'(i));
            end
        end
    end

    always_comb begin
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        rsp_ready_o = '0;
        routable    = '0;
        rsp_fire    = '0;
        for (int i = 0; i < NumInp; i++) begin
            for (int t = 0; t < NumOut; t++) begin
                if (tgt_q[i] == SelWidth'(t)) begin
                    rsp_data_o[i*RspWidth +: RspWidth] = rdata[t];
                    rsp_valid_o[i] = rsp_valid_i[t] & hit[i][t];
                end
                if (hit[i][t]) begin
                    routable[t]    = 1'b1;
                    rsp_ready_o[t] = rsp_ready_i[i];
                end
            end
            rsp_fire[i] = rsp_valid_o[i] & rsp_ready_i[i];
        end
        err_d = |(rsp_valid_i & ~routable);
    end

    always_comb begin
        for (int i = 0; i < NumInp; i++) begin
            cnt_d[i] = cnt_q[i];
            tgt_d[i] = tgt_q[i];
            if (req_fire[i]) begin
                tgt_d[i] = sel[i];
            end
            if (req_fire[i] && !rsp_fire[i]) begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end else if (!req_fire[i] && rsp_fire[i]) begin
                cnt_d[i] = cnt_q[i] - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumInp; i++) begin
                cnt_q[i] <= '0;
                tgt_q[i] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumInp; i++) begin
                cnt_q[i] <= cnt_d[i];
                tgt_q[i] <= tgt_d[i];
            end
            err_q <= err_d;
        end
    end

    assign rsp_err_o = err_q;

    for (genvar gi = 0; gi < NumInp; gi++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(req_fire[gi] && !rsp_fire[gi] && (cnt_q[gi] == CntWidth'(MaxTxns))));
        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(rsp_fire[gi] && !req_fire[gi] && (cnt_q[gi] == '0)));
        a_cnt_range: assert property (@(posedge clk_i) disable iff (rst_i)
            (cnt_q[gi] <= CntWidth'(MaxTxns)));
    end

endmodule

// File: tb/tb_stream_xbar_rsp_router.sv
// Directed bench for stream_xbar_rsp_router: a vector table plus hand-built
// multi-cycle sequences; a second instance with three initiators covers out-of-range indices.
module tb_stream_xbar_rsp_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rv, rs, rr, pv, pi, pr;
    logic [63:0] pd;
    logic [1:0]  rvo, rro, pvo, pro, busy;
    logic [63:0] pdo;
    logic        err;

    logic [2:0]  x_rv, x_rr, x_pr, x_rvo, x_rro, x_pvo, x_busy;
    logic [2:0]  x_rs;
    logic [1:0]  x_pv, x_pro;
    logic [3:0]  x_pi;
    logic [63:0] x_pd;
    logic [95:0] x_pdo;
    logic        x_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_xbar_rsp_router #(.NumInp(2), .NumOut(2), .RspWidth(32), .MaxTxns(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(rv), .req_ready_o(rro), .req_sel_i(rs), .req_valid_o(rvo),
        .req_ready_i(rr), .rsp_data_i(pd), .rsp_idx_i(pi), .rsp_valid_i(pv),
        .rsp_ready_o(pro), .rsp_data_o(pdo), .rsp_valid_o(pvo), .rsp_ready_i(pr),
        .busy_o(busy), .rsp_err_o(err)
    );

    stream_xbar_rsp_router #(.NumInp(3), .NumOut(2), .RspWidth(32), .MaxTxns(4)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(x_rv), .req_ready_o(x_rro), .req_sel_i(x_rs), .req_valid_o(x_rvo),
        .req_ready_i(x_rr), .rsp_data_i(x_pd), .rsp_idx_i(x_pi), .rsp_valid_i(x_pv),
        .rsp_ready_o(x_pro), .rsp_data_o(x_pdo), .rsp_valid_o(x_pvo), .rsp_ready_i(x_pr),
        .busy_o(x_busy), .rsp_err_o(x_err)
    );

    typedef struct {
        logic [1:0]  rv, rs, rr, pv, pi, pr;
        logic [31:0] d0, d1;
        logic [1:0]  e_rvo, e_rro, e_pvo, e_pro, e_busy;
        logic        e_err;
        logic [31:0] e_q0, e_q1;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rv = '0; rs = '0; rr = '0; pv = '0; pi = '0; pr = '0; pd = '0;
    endtask

    task automatic set_vec(input int n,
                           input logic [1:0] v_rv, input logic [1:0] v_rs, input logic [1:0] v_rr,
                           input logic [1:0] v_pv, input logic [1:0] v_pi, input logic [1:0] v_pr,
                           input logic [31:0] v_d0, input logic [31:0] v_d1,
                           input logic [1:0] x_rvo_e, input logic [1:0] x_rro_e,
                           input logic [1:0] x_pvo_e, input logic [1:0] x_pro_e,
                           input logic [1:0] x_busy_e, input logic x_err_e,
                           input logic [31:0] x_q0, input logic [31:0] x_q1);
        vecs[n].rv = v_rv; vecs[n].rs = v_rs; vecs[n].rr = v_rr;
        vecs[n].pv = v_pv; vecs[n].pi = v_pi; vecs[n].pr = v_pr;
        vecs[n].d0 = v_d0; vecs[n].d1 = v_d1;
        vecs[n].e_rvo = x_rvo_e; vecs[n].e_rro = x_rro_e;
        vecs[n].e_pvo = x_pvo_e; vecs[n].e_pro = x_pro_e;
        vecs[n].e_busy = x_busy_e; vecs[n].e_err = x_err_e;
        vecs[n].e_q0 = x_q0; vecs[n].e_q1 = x_q1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        x_rv = '0; x_rs = '0; x_rr = '0; x_pr = '0; x_pv = '0; x_pi = '0; x_pd = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        //       n  rv     rs     rr     pv     pi     pr     d0            d1            rvo    rro    pvo    pro    busy   err   q0            q1
        set_vec(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,       32'h0);
        set_vec(1, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,       32'h0);
        set_vec(2, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       2'b10, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 32'h0,       32'h0);
        set_vec(3, 2'b00, 2'b00, 2'b00, 2'b11, 2'b01, 2'b11, 32'h2222_0000, 32'h1111_0000, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11, 1'b0, 32'h1111_0000, 32'h2222_0000);
        set_vec(4, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 32'h0,       32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,       32'h0);
        set_vec(5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 32'h0,       32'h0);
        set_vec(6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 32'h0,       32'h0,       2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,       32'h0);

        for (int n = 0; n < 7; n++) begin
            rv = vecs[n].rv; rs = vecs[n].rs; rr = vecs[n].rr;
            pv = vecs[n].pv; pi = vecs[n].pi; pr = vecs[n].pr;
            pd = {vecs[n].d1, vecs[n].d0};
            #1;
            chk($sformatf("v%0d req_valid_o", n), 32'(rvo), 32'(vecs[n].e_rvo));
            chk($sformatf("v%0d req_ready_o", n), 32'(rro), 32'(vecs[n].e_rro));
            chk($sformatf("v%0d rsp_valid_o", n), 32'(pvo), 32'(vecs[n].e_pvo));
            chk($sformatf("v%0d rsp_ready_o", n), 32'(pro), 32'(vecs[n].e_pro));
            chk($sformatf("v%0d busy_o", n), 32'(busy), 32'(vecs[n].e_busy));
            chk($sformatf("v%0d rsp_err_o", n), 32'(err), 32'(vecs[n].e_err));
            if (vecs[n].e_pvo[0]) chk($sformatf("v%0d rsp_data_o0", n), pdo[31:0], vecs[n].e_q0);
            if (vecs[n].e_pvo[1]) chk($sformatf("v%0d rsp_data_o1", n), pdo[63:32], vecs[n].e_q1);
            tick();
        end

        // Reset mid-operation
        set_idle();
        rv = 2'b01; rs = 2'b01; rr = 2'b01;
        for (int k = 0; k < 3; k++) begin
            #1 chk("s1 issue", 32'(rvo), 32'h1);
            tick();
        end
        set_idle();
        #1 chk("s1 busy before reset", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("s1 busy after reset", 32'(busy), 32'h0);
        chk("s1 err after reset", 32'(err), 32'h0);
        pv = 2'b10; pi = 2'b00; pd[63:32] = 32'hCAFE_F00D; pr = 2'b11;
        #1 chk("s1 stale rsp_ready", 32'(pro), 32'h0);
        chk("s1 stale rsp_valid", 32'(pvo), 32'h0);
        tick();
        set_idle();
        #1 chk("s1 err pulse", 32'(err), 32'h1);
        tick();
        #1 chk("s1 err cleared", 32'(err), 32'h0);

        // Full stall at MaxTxns
        set_idle();
        rv = 2'b10; rs = 2'b00; rr = 2'b10;
        for (int k = 0; k < 4; k++) begin
            #1 chk("s2 fill", 32'(rvo), 32'h2);
            tick();
        end
        #1 chk("s2 full valid", 32'(rvo), 32'h0);
        chk("s2 full ready", 32'(rro), 32'h0);
        chk("s2 busy", 32'(busy), 32'h2);
        pv = 2'b01; pi = 2'b01; pr = 2'b10; pd[31:0] = 32'h0000_00A5;
        #1 chk("s2 same-cycle gate", 32'(rvo), 32'h0);
        chk("s2 rsp valid", 32'(pvo), 32'h2);
        chk("s2 rsp ready", 32'(pro), 32'h1);
        tick();
        pv = 2'b00; pr = 2'b00;
        #1 chk("s2 refill fire", 32'(rvo), 32'h2);
        tick();
        rv = 2'b00; pv = 2'b01; pi = 2'b01; pr = 2'b10;
        for (int k = 0; k < 4; k++) begin
            pd[31:0] = 32'h0000_00B0 + 32'(k);
            #1 chk("s2 drain valid", 32'(pvo), 32'h2);
            chk("s2 drain data", pdo[63:32], 32'h0000_00B0 + 32'(k));
            tick();
        end
        set_idle();
        #1 chk("s2 drained", 32'(busy), 32'h0);

        // Target switch
        rv = 2'b01; rs = 2'b00; rr = 2'b01;
        for (int k = 0; k < 2; k++) begin
            #1 chk("s3 issue t0", 32'(rvo), 32'h1);
            tick();
        end
        rs = 2'b01;
        #1 chk("s3 stall valid", 32'(rvo), 32'h0);
        chk("s3 stall ready", 32'(rro), 32'h0);
        pv = 2'b01; pi = 2'b00; pr = 2'b01;
        for (int k = 0; k < 2; k++) begin
            #1 chk("s3 stall while drain", 32'(rvo), 32'h0);
            chk("s3 drain valid", 32'(pvo), 32'h1);
            tick();
        end
        pv = 2'b00; pr = 2'b00;
        #1 chk("s3 switch fire", 32'(rvo), 32'h1);
        chk("s3 idle at switch", 32'(busy), 32'h0);
        tick();
        rv = 2'b00; pv = 2'b10; pi = 2'b00; pd[63:32] = 32'h5A5A_5A5A; pr = 2'b01;
        #1 chk("s3 new tgt valid", 32'(pvo), 32'h1);
        chk("s3 new tgt data", pdo[31:0], 32'h5A5A_5A5A);
        chk("s3 new tgt ready", 32'(pro), 32'h2);
        chk("s3 busy", 32'(busy), 32'h1);
        tick();
        set_idle();
        #1 chk("s3 drained", 32'(busy), 32'h0);

        // Routing with backpressure
        rv = 2'b10; rs = 2'b10; rr = 2'b10;
        #1 chk("s4 issue", 32'(rvo), 32'h2);
        tick();
        set_idle();
        pv = 2'b10; pi = 2'b10; pd[63:32] = 32'hDEAD_BEEF; pr = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1 chk("s4 hold valid", 32'(pvo), 32'h2);
            chk("s4 hold data", pdo[63:32], 32'hDEAD_BEEF);
            chk("s4 hold ready", 32'(pro), 32'h0);
            tick();
        end
        pr = 2'b10;
        #1 chk("s4 fire valid", 32'(pvo), 32'h2);
        chk("s4 fire ready", 32'(pro), 32'h2);
        tick();
        set_idle();
        #1 chk("s4 drained", 32'(busy), 32'h0);
        chk("s4 no err", 32'(err), 32'h0);

        // Simultaneous request and response fire
        rv = 2'b01; rs = 2'b00; rr = 2'b01;
        tick();
        tick();
        pv = 2'b01; pi = 2'b00; pr = 2'b01;
        #1 chk("s5 req fire", 32'(rvo), 32'h1);
        chk("s5 rsp fire", 32'(pvo), 32'h1);
        tick();
        rv = 2'b00;
        #1 chk("s5 busy", 32'(busy), 32'h1);
        tick();
        #1 chk("s5 still busy after one", 32'(busy), 32'h1);
        tick();
        set_idle();
        #1 chk("s5 drained after two", 32'(busy), 32'h0);

        // Out-of-range index on the three-initiator instance
        x_pv = 2'b01; x_pi = 4'b0011; x_pr = 3'b111;
        #1 chk("s6 ready", 32'(x_pro), 32'h0);
        chk("s6 valid", 32'(x_pvo), 32'h0);
        chk("s6 err before", 32'(x_err), 32'h0);
        tick();
        #1 chk("s6 err 1", 32'(x_err), 32'h1);
        chk("s6 ready held", 32'(x_pro), 32'h0);
        tick();
        x_pv = 2'b00;
        #1 chk("s6 err 2", 32'(x_err), 32'h1);
        tick();
        #1 chk("s6 err clear", 32'(x_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
